// File: rtl/host_msix_vec_monitor.sv
// Multi-vector MSI-X monitor: matches host dword writes against a programmable
// address/data table and keeps per-vector pending, coalesce and event-count state.
module host_msix_vec_monitor #(
    parameter int NUM_VEC = 8,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 8,
    parameter logic [ADDR_W-1:0] V0_ADDR = 'h1,
    parameter logic [DATA_W-1:0] V0_DATA = 'h12345678,
    localparam int IDX_W = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_valid,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic [DATA_W-1:0]  cfg_data,
    input  logic               cfg_en,
    input  logic [NUM_VEC-1:0] mask,
    input  logic [NUM_VEC-1:0] clr,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [NUM_VEC-1:0] pend,
    output logic [NUM_VEC-1:0] ovf,
    output logic [CNT_W-1:0]   rd_cnt,
    output logic               intr_any,
    output logic               match_pulse
);

    logic [ADDR_W-1:0]  addr_q [NUM_VEC];
    logic [ADDR_W-1:0]  addr_d [NUM_VEC];
    logic [DATA_W-1:0]  data_q [NUM_VEC];
    logic [DATA_W-1:0]  data_d [NUM_VEC];
    logic [CNT_W-1:0]   cnt_q  [NUM_VEC];
    logic [CNT_W-1:0]   cnt_d  [NUM_VEC];
    logic [NUM_VEC-1:0] en_q, en_d;
    logic [NUM_VEC-1:0] pend_q, pend_d;
    logic [NUM_VEC-1:0] ovf_q, ovf_d;
    logic               match_pulse_q, match_pulse_d;

    logic [NUM_VEC-1:0] hit;
    logic [IDX_W-1:0]   sel;
    logic               any_hit;

    for (genvar gi = 0; gi < NUM_VEC; gi++) begin : g_hit
        assign hit[gi] = wr_valid & en_q[gi] & (wr_addr == addr_q[gi]) & (wr_data == data_q[gi]);
    end

    // Lowest-index hit wins; scanning downward leaves the smallest index in sel.
    always_comb begin
        sel = '0;
        for (int i = NUM_VEC - 1; i >= 0; i--) begin
            if (hit[i]) sel = IDX_W'(i);
        end
        any_hit = |hit;
    end

    always_comb begin
        match_pulse_d = any_hit;
        for (int i = 0; i < NUM_VEC; i++) begin
            logic rec;
            logic cfg_hit;
            rec     = any_hit && (sel == IDX_W'(i));
            cfg_hit = cfg_we && (cfg_idx == IDX_W'(i));

            addr_d[i] = cfg_hit ? cfg_addr : addr_q[i];
            data_d[i] = cfg_hit ? cfg_data : data_q[i];
            en_d[i]   = cfg_hit ? cfg_en   : en_q[i];

            // Priority: config reset, then record (set beats clear), then clear.
            if (cfg_hit)
                pend_d[i] = 1'b0;
            else if (rec)
                pend_d[i] = 1'b1;
            else if (clr[i])
                pend_d[i] = 1'b0;
            else
                pend_d[i] = pend_q[i];

            // A clear in the same cycle wipes the prior pending, so no coalesce.
            if (cfg_hit || clr[i])
                ovf_d[i] = 1'b0;
            else if (rec && pend_q[i])
                ovf_d[i] = 1'b1;
            else
                ovf_d[i] = ovf_q[i];

            if (cfg_hit)
                cnt_d[i] = '0;
            else if (rec && (cnt_q[i] != {CNT_W{1'b1}}))
                cnt_d[i] = cnt_q[i] + 1'b1;
            else
                cnt_d[i] = cnt_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_VEC; i++) begin
                addr_q[i] <= (i == 0) ? V0_ADDR : '0;
                data_q[i] <= (i == 0) ? V0_DATA : '0;
                cnt_q[i]  <= '0;
            end
            en_q          <= NUM_VEC'(1);
            pend_q        <= '0;
            ovf_q         <= '0;
            match_pulse_q <= 1'b0;
        end else begin
            addr_q        <= addr_d;
            data_q        <= data_d;
            cnt_q         <= cnt_d;
            en_q          <= en_d;
            pend_q        <= pend_d;
            ovf_q         <= ovf_d;
            match_pulse_q <= match_pulse_d;
        end
    end

    always_comb begin
        rd_cnt = '0;
        for (int i = 0; i < NUM_VEC; i++) begin
            if (rd_idx == IDX_W'(i)) rd_cnt = cnt_q[i];
        end
    end

    assign pend        = pend_q;
    assign ovf         = ovf_q;
    assign intr_any    = |(pend_q & ~mask);
    assign match_pulse = match_pulse_q;

endmodule

// File: tb/tb_host_msix_vec_monitor.sv
// Directed bench for host_msix_vec_monitor with a transaction-level reference
// model compared every cycle, plus literal spot checks that pin the model.
module tb_host_msix_vec_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic [63:0] wr_addr;
    logic [31:0] wr_data;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic [63:0] cfg_addr;
    logic [31:0] cfg_data;
    logic        cfg_en;
    logic [7:0]  mask;
    logic [7:0]  clr;
    logic [2:0]  rd_idx;
    logic [7:0]  pend;
    logic [7:0]  ovf;
    logic [7:0]  rd_cnt;
    logic        intr_any;
    logic        match_pulse;

    int tests  = 0;
    int failed = 0;
    int ncyc   = 0;

    host_msix_vec_monitor dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_en(cfg_en),
        .mask(mask), .clr(clr), .rd_idx(rd_idx),
        .pend(pend), .ovf(ovf), .rd_cnt(rd_cnt),
        .intr_any(intr_any), .match_pulse(match_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the table and per-vector event bookkeeping as plain arrays.
    logic [63:0] m_addr [8];
    logic [31:0] m_data [8];
    bit          m_en   [8];
    int          m_cnt  [8];
    bit   [7:0]  m_pend;
    bit   [7:0]  m_ovf;
    bit          m_pulse;
    int          m_sel;

    task automatic m_reset();
        for (int i = 0; i < 8; i++) begin
            m_addr[i] = (i == 0) ? 64'h1 : 64'h0;
            m_data[i] = (i == 0) ? 32'h12345678 : 32'h0;
            m_en[i]   = (i == 0);
            m_cnt[i]  = 0;
        end
        m_pend  = '0;
        m_ovf   = '0;
        m_pulse = 1'b0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_reset();
        end else begin
            m_sel = -1;
            if (wr_valid)
                for (int i = 7; i >= 0; i--)
                    if (m_en[i] && m_addr[i] == wr_addr && m_data[i] == wr_data) m_sel = i;
            m_pend &= ~clr;
            m_ovf  &= ~clr;
            if (m_sel >= 0) begin
                if (m_pend[m_sel]) m_ovf[m_sel] = 1'b1;
                m_pend[m_sel] = 1'b1;
                if (m_cnt[m_sel] < 255) m_cnt[m_sel]++;
            end
            if (cfg_we) begin
                m_addr[cfg_idx] = cfg_addr;
                m_data[cfg_idx] = cfg_data;
                m_en[cfg_idx]   = cfg_en;
                m_pend[cfg_idx] = 1'b0;
                m_ovf[cfg_idx]  = 1'b0;
                m_cnt[cfg_idx]  = 0;
            end
            m_pulse = (m_sel >= 0);
        end
    end

    always @(negedge clk) begin
        check("cyc_pend", pend, m_pend);
        check("cyc_ovf", ovf, m_ovf);
        check("cyc_pulse", match_pulse, m_pulse);
        check("cyc_intr", intr_any, |(m_pend & ~mask));
        check("cyc_rdcnt", rd_cnt, m_cnt[rd_idx]);
    end

    // One edge of stimulus; strobes are dropped 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        ncyc++;
        $display("[TB] cyc %0d wr=%0b %0h/%0h cfg=%0b idx=%0d clr=%0h -> pend=%0h ovf=%0h pulse=%0b",
                 ncyc, wr_valid, wr_addr, wr_data, cfg_we, cfg_idx, clr, pend, ovf, match_pulse);
        wr_valid = 1'b0;
        cfg_we   = 1'b0;
        clr      = '0;
    endtask

    task automatic wr(input logic [63:0] a, input logic [31:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick();
    endtask

    task automatic cfg(input logic [2:0] idx, input logic [63:0] a, input logic [31:0] d, input logic en);
        cfg_we   = 1'b1;
        cfg_idx  = idx;
        cfg_addr = a;
        cfg_data = d;
        cfg_en   = en;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        wr_valid = 0; wr_addr = '0; wr_data = '0;
        cfg_we = 0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0; cfg_en = 0;
        mask = '0; clr = '0; rd_idx = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_pend", pend, 0);
        check("rst_ovf", ovf, 0);
        check("rst_intr", intr_any, 0);
        check("rst_pulse", match_pulse, 0);
        check("rst_cnt0", rd_cnt, 0);

        // Default vector 0 entry
        wr(64'h1, 32'h12345678);
        check("v0_pend", pend, 8'h01);
        check("v0_pulse", match_pulse, 1);
        check("v0_intr", intr_any, 1);
        check("v0_cnt", rd_cnt, 1);
        tick();
        check("v0_pulse_drop", match_pulse, 0);
        clr = 8'h01;
        tick();

        // Vector 3: data mismatch, then match
        cfg(3'd3, 64'hFEE0_0030, 32'h33, 1'b1);
        wr(64'hFEE0_0030, 32'h34);
        check("v3_nomatch_pend", pend, 8'h00);
        check("v3_nomatch_pulse", match_pulse, 0);
        wr(64'hFEE0_0030, 32'h33);
        check("v3_pend", pend[3], 1);
        check("v3_ovf", ovf[3], 0);

        // Identical entries: lowest index wins
        cfg(3'd2, 64'hFEE0_0050, 32'h55, 1'b1);
        cfg(3'd5, 64'hFEE0_0050, 32'h55, 1'b1);
        wr(64'hFEE0_0050, 32'h55);
        check("prio_pend", pend, 8'h0C);
        rd_idx = 3'd2; #1 check("prio_cnt2", rd_cnt, 1);
        rd_idx = 3'd5; #1 check("prio_cnt5", rd_cnt, 0);

        // Coalescing on vector 3, then clear racing a hit
        wr(64'hFEE0_0030, 32'h33);
        wr(64'hFEE0_0030, 32'h33);
        rd_idx = 3'd3; #1 check("coal_cnt3", rd_cnt, 3);
        check("coal_ovf3", ovf[3], 1);
        clr = 8'h08;
        wr(64'hFEE0_0030, 32'h33);
        check("clrhit_pend3", pend[3], 1);
        check("clrhit_ovf3", ovf[3], 0);
        check("clrhit_cnt3", rd_cnt, 4);

        // Disabled entry never hits
        cfg(3'd4, 64'hFEE0_0040, 32'h44, 1'b0);
        wr(64'hFEE0_0040, 32'h44);
        check("dis_pulse", match_pulse, 0);
        check("dis_pend4", pend[4], 0);

        // Config write racing a hit on the same entry: config reset wins
        cfg_we = 1'b1; cfg_idx = 3'd3; cfg_addr = 64'hFEE0_0030; cfg_data = 32'h33; cfg_en = 1'b1;
        wr(64'hFEE0_0030, 32'h33);
        check("cfghit_pend3", pend[3], 0);
        check("cfghit_ovf3", ovf[3], 0);
        rd_idx = 3'd3; #1 check("cfghit_cnt3", rd_cnt, 0);

        // Saturation and masking on vector 0
        clr = 8'hFF;
        tick();
        for (int k = 0; k < 300; k++) wr(64'h1, 32'h12345678);
        rd_idx = 3'd0; #1 check("sat_cnt0", rd_cnt, 255);
        tick();
        mask = 8'h01; #1
        check("mask_intr", intr_any, 0);
        check("mask_pend0", pend[0], 1);
        tick();
        mask = 8'h00; #1
        check("unmask_intr", intr_any, 1);

        // Fill all pending bits, then async reset between edges
        for (int i = 1; i < 8; i++) cfg(3'(i), 64'h100 + 64'(i), 32'(i), 1'b1);
        for (int i = 1; i < 8; i++) wr(64'h100 + 64'(i), 32'(i));
        check("all_pend", pend, 8'hFF);
        #2 rst = 1'b1;
        #1;
        check("arst_pend", pend, 0);
        check("arst_ovf", ovf, 0);
        check("arst_intr", intr_any, 0);
        check("arst_pulse", match_pulse, 0);
        check("arst_cnt", rd_cnt, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        wr(64'h1, 32'h12345678);
        check("post_rst_pend", pend, 8'h01);
        check("post_rst_pulse", match_pulse, 1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
